// File: rtl/pqc_params_pkg.sv
// Shared ring parameters and FSM state type for the coefficient datapath
// (this multiplier and the modular reducer).
package pqc_params_pkg;

    localparam int unsigned P      = 1049089;  // 2^20 + 2^9 + 1, NTT-friendly for N = 256
    localparam int unsigned B      = 21;       // ceil(log2 P)
    localparam int unsigned N      = 256;
    localparam int unsigned NB     = 8;        // log2 N
    localparam int unsigned T      = 16;       // plaintext modulus
    localparam int unsigned T_HALF = T / 2;
    localparam int unsigned PROD_W = 2 * B;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/coeff_seq_mult.sv
// Radix-2 shift-add multiplier: one b x b -> 2b product every b+2 cycles,
// with an operand range flag for the downstream reducer.
module coeff_seq_mult
    import pqc_params_pkg::*;
#(
    parameter int unsigned b       = B,
    parameter int unsigned p       = P,
    parameter int unsigned in_size = 2 * B - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [b-1:0]     op_a,
    input  logic [b-1:0]     op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [in_size:0] product,
    output logic             range_err
);

    localparam int unsigned W = in_size + 1;
    localparam logic [b-1:0] PMod = b'(p);

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   prod_q, prod_d;
    logic [b-1:0]   mplier_q, mplier_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           err_q, err_d;
    logic           rerr_q, rerr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rerr_q   <= rerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rerr_d   = rerr_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d    = '0;
                    mcand_d  = W'(op_a);
                    mplier_d = op_b;
                    cnt_d    = 5'(b - 1);
                    err_d    = (op_a >= PMod) || (op_b >= PMod);
                    rerr_d   = 1'b0;
                    state_d  = MUL;
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    // Publish only the finished product so no partial sum is ever visible.
                    cnt_d   = 5'd0;
                    prod_d  = acc_d;
                    rerr_d  = err_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = prod_q;
    assign range_err = rerr_q;

endmodule

// File: tb/tb_coeff_seq_mult.sv
// Directed-vector bench for coeff_seq_mult: latency, products, range flag,
// backpressure and mid-operation reset.
module tb_coeff_seq_mult;
    import pqc_params_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] op_a;
    logic [20:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [41:0] product;
    logic        range_err;

    int n_tests = 0;
    int n_fail  = 0;

    coeff_seq_mult dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [20:0] a, input logic [20:0] bb);
        check("in_ready_before_send", 64'(in_ready), 64'd1);
        op_a     = a;
        op_b     = bb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Latency in cycles from the handshake cycle to the first out_valid cycle.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            if (lat < 0) begin
                if (out_valid) lat = k;
                else tick();
            end
        end
        if (lat < 0) check("out_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input string tag, input logic [20:0] a, input logic [20:0] bb,
                       input logic [41:0] exp_prod, input logic exp_err);
        int lat;
        out_ready = 1'b1;
        send(a, bb);
        wait_out(lat);
        check({tag, "_latency"}, 64'(lat), 64'd22);
        check({tag, "_product"}, 64'(product), 64'(exp_prod));
        check({tag, "_range_err"}, 64'(range_err), 64'(exp_err));
        tick();
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready_rise"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [41:0] held;
        reset     = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);

        run("3x5", 21'd3, 21'd5, 42'd15, 1'b0);

        run("pm1sq", 21'd1049088, 21'd1049088, 42'd1100585631744, 1'b0);
        check("pm1sq_msb", 64'(product[41]), 64'd0);
        check("pm1sq_mod_p", 64'(product) % 64'(P), 64'd1);

        run("0xmax", 21'd0, 21'd2097151, 42'd0, 1'b1);
        run("maxx0", 21'd2097151, 21'd0, 42'd0, 1'b1);
        run("px1", 21'd1049089, 21'd1, 42'd1049089, 1'b1);
        run("7x9", 21'd7, 21'd9, 42'd63, 1'b0);

        // Backpressure with a second pair waiting on in_valid.
        out_ready = 1'b0;
        send(21'd11, 21'd13);
        op_a     = 21'd100;
        op_b     = 21'd200;
        in_valid = 1'b1;
        wait_out(lat);
        check("bp_latency", 64'(lat), 64'd22);
        check("bp_product", 64'(product), 64'd143);
        held = product;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_product_hold", 64'(product), 64'(held));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 25; i++) tick();
        check("bp_no_second_latch", 64'(out_valid), 64'd0);
        check("bp_product_retained", 64'(product), 64'd143);

        // Reset in the middle of a multiplication.
        send(21'd123, 21'd456);
        for (int i = 0; i < 10; i++) tick();
        check("mid_in_ready_low", 64'(in_ready), 64'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_product", 64'(product), 64'd0);
        run("2x2", 21'd2, 21'd2, 42'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
